// File: rtl/tt_factory_test_seq.sv
// tt_factory_test_seq: factory-test sequencer for the bidirectional IO pins.
// Runs UP (count-up drive), DOWN (count-down drive with loopback check),
// TURN (all pins released) and, optionally, LISTEN (fold pin data into a
// rotate-XOR signature) before settling in DONE with pass/fail results.
// Optional feature macro: FACTORY_SEQ_LISTEN_EN enables the LISTEN phase;
// without it TURN goes straight to DONE and sig is tied to zero.
module tt_factory_test_seq #(
  parameter int unsigned PHASE_LEN = 256,
  parameter int unsigned TURN_LEN  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] sig,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP     = 3'd1,
    DOWN   = 3'd2,
    TURN   = 3'd3,
    LISTEN = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [8:0] PhaseLast = 9'(PHASE_LEN - 1);
  localparam logic [8:0] TurnLast  = 9'(TURN_LEN - 1);

  state_t     state_q, state_d;
  logic [8:0] pc_q, pc_d;
  logic [7:0] uio_out_q, uio_out_d;
  logic [7:0] uio_oe_q, uio_oe_d;
  logic [7:0] err_q, err_d;
  logic       pass_q, pass_d;
`ifdef FACTORY_SEQ_LISTEN_EN
  logic [7:0] sig_q, sig_d;
`endif

  // State, phase counter, pin registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= 9'd0;
      uio_out_q <= 8'h00;
      uio_oe_q  <= 8'h00;
      err_q     <= 8'h00;
      pass_q    <= 1'b0;
`ifdef FACTORY_SEQ_LISTEN_EN
      sig_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      uio_out_q <= uio_out_d;
      uio_oe_q  <= uio_oe_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
`ifdef FACTORY_SEQ_LISTEN_EN
      sig_q     <= sig_d;
`endif
    end
  end

  // Next-state and phase counter: pc restarts at every phase entry and
  // parks at zero in IDLE/DONE; abort overrides everything including start.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q + 9'd1;
    case (state_q)
      IDLE:   if (start) state_d = UP;
      UP:     if (pc_q == PhaseLast) state_d = DOWN;
      DOWN:   if (pc_q == PhaseLast) state_d = TURN;
`ifdef FACTORY_SEQ_LISTEN_EN
      TURN:   if (pc_q == TurnLast) state_d = LISTEN;
      LISTEN: if (pc_q == PhaseLast) state_d = DONE;
`else
      TURN:   if (pc_q == TurnLast) state_d = DONE;
`endif
      DONE:   if (start) state_d = UP;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    if ((state_d != state_q) || (state_d == IDLE) || (state_d == DONE)) begin
      pc_d = 9'd0;
    end
  end

  // Datapath next values: loopback checking, signature folding, result
  // clearing at UP entry, pass capture at DONE entry, and pin drive derived
  // from the upcoming state so pins are only driven during UP/DOWN.
  always_comb begin
    err_d     = err_q;
    pass_d    = pass_q;
    uio_out_d = 8'h00;
    uio_oe_d  = 8'h00;
`ifdef FACTORY_SEQ_LISTEN_EN
    sig_d     = sig_q;
    if (state_q == LISTEN) begin
      sig_d = {sig_q[6:0], sig_q[7]} ^ uio_in;
    end
`endif
    if (((state_q == UP) || (state_q == DOWN)) && (uio_in != uio_out_q) &&
        (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
    if ((state_d == UP) && (state_q != UP)) begin
      err_d  = 8'h00;
      pass_d = 1'b0;
`ifdef FACTORY_SEQ_LISTEN_EN
      sig_d  = 8'h00;
`endif
    end
    if ((state_d == DONE) && (state_q != DONE)) begin
      pass_d = (err_d == 8'h00);
    end
    case (state_d)
      UP: begin
        uio_oe_d  = 8'hFF;
        uio_out_d = pc_d[7:0];
      end
      DOWN: begin
        uio_oe_d  = 8'hFF;
        uio_out_d = 8'hFF - pc_d[7:0];
      end
      default: begin
        uio_oe_d  = 8'h00;
        uio_out_d = 8'h00;
      end
    endcase
  end

  // Status outputs and observation bus selection by current state.
  always_comb begin
    uio_out   = uio_out_q;
    uio_oe    = uio_oe_q;
    err_count = err_q;
    pass      = pass_q;
    phase     = state_q;
    busy      = (state_q == UP) || (state_q == DOWN) ||
                (state_q == TURN) || (state_q == LISTEN);
    done      = (state_q == DONE);
`ifdef FACTORY_SEQ_LISTEN_EN
    sig       = sig_q;
`else
    sig       = 8'h00;
`endif
    case (state_q)
      UP, DOWN: uo_out = uio_out_q;
      TURN:     uo_out = err_q;
      LISTEN:   uo_out = uio_in;
`ifdef FACTORY_SEQ_LISTEN_EN
      DONE:     uo_out = sig_q;
`else
      DONE:     uo_out = err_q;
`endif
      default:  uo_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tt_factory_test_seq.sv
// tb_tt_factory_test_seq: directed bench for the factory-test sequencer.
// Main instance uses PHASE_LEN=4, TURN_LEN=2; a second instance with
// PHASE_LEN=256 exercises err_count saturation.
module tb_tt_factory_test_seq;

  logic       clock;
  logic       reset;
  logic       start, abort;
  logic [7:0] uioIn, uioOut, uioOe, uoOut, errCount, sigOut;
  logic       busy, done, pass;
  logic [2:0] phase;
  int         mode;

  logic       satStart;
  logic [7:0] satUioIn, satUioOut, satUioOe, satUoOut, satErr, satSig;
  logic       satBusy, satDone, satPass;
  logic [2:0] satPhase;

  int compared;
  int mismatched;

  logic [7:0] expSeq [8];
  logic [7:0] expSig;

  tt_factory_test_seq #(.PHASE_LEN(4), .TURN_LEN(2)) dut (
    .clk(clock), .rst(reset), .start(start), .abort(abort),
    .uio_in(uioIn), .uio_out(uioOut), .uio_oe(uioOe), .uo_out(uoOut),
    .busy(busy), .done(done), .pass(pass), .err_count(errCount),
    .sig(sigOut), .phase(phase)
  );

  tt_factory_test_seq #(.PHASE_LEN(256), .TURN_LEN(2)) dutSat (
    .clk(clock), .rst(reset), .start(satStart), .abort(1'b0),
    .uio_in(satUioIn), .uio_out(satUioOut), .uio_oe(satUioOe), .uo_out(satUoOut),
    .busy(satBusy), .done(satDone), .pass(satPass), .err_count(satErr),
    .sig(satSig), .phase(satPhase)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Test fixture loopback: 0 = clean, 1 = bit 0 stuck high; A5 when released.
  always_comb begin
    uioIn = 8'hA5;
    if (uioOe == 8'hFF) begin
      if (mode == 1) uioIn = uioOut | 8'h01;
      else           uioIn = uioOut;
    end
  end

  // Saturation fixture always returns the inverted pins.
  assign satUioIn = ~satUioOut;

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed test sequence.
  initial begin
    compared   = 0;
    mismatched = 0;
    mode       = 0;
    reset      = 1'b1;
    satStart   = 1'b0;
    applyStimulus(1'b0, 1'b0);
    expSeq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
`ifdef FACTORY_SEQ_LISTEN_EN
    expSig = 8'h55;
`else
    expSig = 8'h00;
`endif

    // Reset state.
    tick(2);
    checkOutput("rst_phase", 32'(phase), 32'd0);
    checkOutput("rst_oe", 32'(uioOe), 32'h00);
    checkOutput("rst_out", 32'(uioOut), 32'h00);
    checkOutput("rst_uo", 32'(uoOut), 32'h00);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_err", 32'(errCount), 32'h00);
    checkOutput("rst_sig", 32'(sigOut), 32'h00);
    reset = 1'b0;
    tick(2);

    // Clean loopback run.
    applyStimulus(1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("clean_up_phase", 32'(phase), 32'd1);
    checkOutput("clean_up_oe", 32'(uioOe), 32'hFF);
    checkOutput("clean_up_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("clean_seq%0d", k), 32'(uioOut), 32'(expSeq[k]));
      if (k == 1) checkOutput("clean_uo_up", 32'(uoOut), 32'h01);
      if (k == 4) checkOutput("clean_down_phase", 32'(phase), 32'd2);
      tick(1);
    end
    checkOutput("clean_turn_phase", 32'(phase), 32'd3);
    checkOutput("clean_turn_oe", 32'(uioOe), 32'h00);
    checkOutput("clean_turn_out", 32'(uioOut), 32'h00);
    checkOutput("clean_turn_uo", 32'(uoOut), 32'h00);
`ifdef FACTORY_SEQ_LISTEN_EN
    tick(2);
    checkOutput("clean_listen_phase", 32'(phase), 32'd4);
    checkOutput("clean_listen_uo", 32'(uoOut), 32'hA5);
    tick(3);
`else
    tick(1);
`endif
    checkOutput("clean_not_done_early", 32'(done), 32'd0);
    tick(1);
    checkOutput("clean_done", 32'(done), 32'd1);
    checkOutput("clean_done_phase", 32'(phase), 32'd5);
    checkOutput("clean_pass", 32'(pass), 32'd1);
    checkOutput("clean_err", 32'(errCount), 32'h00);
    checkOutput("clean_sig", 32'(sigOut), 32'(expSig));
    checkOutput("clean_done_uo", 32'(uoOut), 32'(expSig));
    checkOutput("clean_done_busy", 32'(busy), 32'd0);

    // Stuck pin run, restarted from DONE.
    mode = 1;
    applyStimulus(1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 40 && done !== 1'b1; i++) tick(1);
    checkOutput("stuck_done", 32'(done), 32'd1);
    checkOutput("stuck_err", 32'(errCount), 32'h04);
    checkOutput("stuck_pass", 32'(pass), 32'd0);
`ifdef FACTORY_SEQ_LISTEN_EN
    checkOutput("stuck_uo", 32'(uoOut), 32'h55);
`else
    checkOutput("stuck_uo", 32'(uoOut), 32'h04);
`endif

    // Restart clears err_count; start held during UP is ignored; abort in DOWN.
    applyStimulus(1'b1, 1'b0);
    tick(1);
    checkOutput("restart_err_clr", 32'(errCount), 32'h00);
    checkOutput("restart_phase", 32'(phase), 32'd1);
    tick(2);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    checkOutput("restart_up_hold", 32'(phase), 32'd1);
    tick(1);
    checkOutput("restart_down_entry", 32'(phase), 32'd2);
    checkOutput("restart_down_out", 32'(uioOut), 32'hFF);
    tick(2);
    checkOutput("abort_pre_out", 32'(uioOut), 32'hFD);
    checkOutput("abort_pre_err", 32'(errCount), 32'h03);
    applyStimulus(1'b1, 1'b1);
    tick(1);
    checkOutput("abort_phase", 32'(phase), 32'd0);
    checkOutput("abort_oe", 32'(uioOe), 32'h00);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_out", 32'(uioOut), 32'h00);
    checkOutput("abort_uo", 32'(uoOut), 32'h00);
    checkOutput("abort_err_kept", 32'(errCount), 32'h03);
    tick(1);
    checkOutput("abort_beats_start", 32'(phase), 32'd0);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    checkOutput("abort_idle_stays", 32'(phase), 32'd0);

    // Asynchronous reset in the middle of UP.
    applyStimulus(1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    checkOutput("rstmid_pre_err", 32'(errCount), 32'h01);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_phase", 32'(phase), 32'd0);
    checkOutput("rstmid_err", 32'(errCount), 32'h00);
    checkOutput("rstmid_oe", 32'(uioOe), 32'h00);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(3);
    checkOutput("rstmid_no_autostart", 32'(phase), 32'd0);

    // Saturation with PHASE_LEN=256 and inverted loopback.
    satStart = 1'b1;
    tick(1);
    satStart = 1'b0;
    checkOutput("sat_up_phase", 32'(satPhase), 32'd1);
    tick(100);
    checkOutput("sat_err_100", 32'(satErr), 32'h64);
    tick(155);
    checkOutput("sat_err_255", 32'(satErr), 32'hFF);
    tick(45);
    checkOutput("sat_err_300", 32'(satErr), 32'hFF);
    for (int i = 0; i < 1000 && satDone !== 1'b1; i++) tick(1);
    checkOutput("sat_done", 32'(satDone), 32'd1);
    checkOutput("sat_err_final", 32'(satErr), 32'hFF);
    checkOutput("sat_pass", 32'(satPass), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tt_factory_test_seq.md
# tt_factory_test_seq

Sequencer for the factory-test IO datapath. On `start` it runs a fixed test program over the bidirectional pins: count-up drive, count-down drive with loopback checking, bus turnaround, then an optional listen phase that folds incoming pin data into a signature. It sits between the tile's top-level pins and the test counters. It owns `uio_oe` direction control and reports pass/fail, error count and signature to the top level.

## Interface
- `PHASE_LEN`, 256: cycles spent in each of UP, DOWN and LISTEN phases; legal range 2..256.
- `TURN_LEN`, 2: cycles in TURN with all pins released; legal range 1..4.

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  level; sampled only in IDLE and DONE
- `abort`  in  1  level; return to IDLE from any state
- `uio_in`  in  8  pin input path (loopback in test fixture)
- `uio_out`  out  8  pin output path, registered
- `uio_oe`  out  8  pin output enable, registered, 1 = drive
- `uo_out`  out  8  observation bus
- `busy`  out  1  high in UP, DOWN, TURN, LISTEN
- `done`  out  1  high in DONE
- `pass`  out  1  valid when `done`: `err_count == 0`
- `err_count`  out  8  loopback mismatch count, saturating
- `sig`  out  8  LISTEN signature
- `phase`  out  3  state code: IDLE=0, UP=1, DOWN=2, TURN=3, LISTEN=4, DONE=5

## Operation
- States and transitions:
  - IDLE → UP on `start`.
  - UP → DOWN after PHASE_LEN cycles.
  - DOWN → TURN after PHASE_LEN cycles.
  - TURN → LISTEN after TURN_LEN cycles.
  - LISTEN → DONE after PHASE_LEN cycles.
  - DONE → UP on `start`.
- `abort` forces IDLE from every state. `abort` wins over `start` in the same cycle.
- `start` is ignored while `busy`.
- Entry into UP clears `err_count`, `sig` and the phase counter `pc`.
- UP phase: `uio_oe`=FF; `uio_out`=`pc[7:0]`, running 0,1,2,… .
- DOWN phase: `uio_oe`=FF; `uio_out`=`8'hFF - pc[7:0]`, running FF,FE,… .
- Check in UP/DOWN: each cycle, if `uio_in != uio_out`, `err_count` increments by 1 and saturates at FF.
- TURN: `uio_oe`=00, `uio_out`=00. No checking.
- LISTEN: `uio_oe`=00. Each cycle `sig <= {sig[6:0], sig[7]} ^ uio_in`.
- `pc` is 9 bits. It resets to 0 on every phase entry and the phase ends when `pc == len-1`.
- `uo_out` by state:
  - IDLE: 00.
  - UP/DOWN: `uio_out`.
  - TURN: `err_count`.
  - LISTEN: `uio_in`.
  - DONE: `sig`.
- `err_count`, `sig` and `pass` hold in DONE and IDLE until the next UP entry.
- `abort` clears `done` and forces `uio_oe`=00. It does not clear `err_count` or `sig`.

## Timing
- Reset values:
  - state IDLE, `pc`=0.
  - `uio_out`=00, `uio_oe`=00, `uo_out`=00.
  - `busy`=0, `done`=0, `pass`=0, `err_count`=00, `sig`=00, `phase`=0.
- `start` high at edge N: `phase`=1 and `uio_oe`=FF from edge N+1. The first driven value is 00.
- Loopback compare is same-cycle: `uio_in` is compared against the registered `uio_out` and the result lands in `err_count` at the next edge.
- Phase durations: UP occupies edges N+1..N+PHASE_LEN. DONE is entered at edge N+3·PHASE_LEN+TURN_LEN+1 (with LISTEN compiled in).
- `uio_oe` falls at the same edge TURN is entered. It rises only at UP entry, so there is never a cycle with pins driven outside UP/DOWN.
- `abort` at edge M: IDLE, `uio_oe`=00, `busy`=0, `done`=0 from edge M+1.
- `rst` asserted mid-run forces reset values asynchronously. The sequencer takes no action until `start` is seen after `rst` deasserts.
- `pass` and `done` update at the same edge.

## Configuration
- `FACTORY_SEQ_LISTEN_EN`
  - Defined: LISTEN phase present; `sig` computed as above.
  - Undefined: TURN → DONE directly, `sig` tied to 00, and `uo_out` in DONE shows `err_count`. DONE is entered at edge N+2·PHASE_LEN+TURN_LEN+1.

## Test plan
- Clean loopback: bench ties `uio_in=uio_out` when `uio_oe`=FF and drives `uio_in`=A5 in LISTEN; PHASE_LEN=4, TURN_LEN=2; pulse `start` → `done` at N+15, `pass`=1, `err_count`=00, `uio_out` sequence 00,01,02,03,FF,FE,FD,FC; then `sig`=`uo_out`=the rotate-XOR of 4× A5 (the same 8-bit value as 4× A5 folded from 00).
- Stuck pin: `uio_in` = `uio_out | 8'h01` → `err_count`=04 (UP even values 00, 02 plus DOWN even values FE, FC), `pass`=0.
- Saturation: PHASE_LEN=256, `uio_in`=`~uio_out` → `err_count` saturates at FF and never wraps to 00.
- Abort mid-DOWN at pc=2 → `uio_oe`=00, `phase`=0, `busy`=0 next cycle; `start` held concurrently with `abort` has no effect.
- Restart from DONE: second `start` clears `err_count` from 04 to 00 at UP entry; `start` asserted during UP is ignored (phase timing unchanged).
- Build without `FACTORY_SEQ_LISTEN_EN`, PHASE_LEN=4 → `done` at N+11, `sig`=00, `uo_out`=`err_count`.
